// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the main memory responder.
// The FSM state encoding and block geometry helpers live here.
package mem_rsp_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 16;
  localparam int CNT_W          = 8;

  // Block type at default geometry; parameterized modules build their own.
  typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } op_t;

  function automatic int off_w(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int mem_idx_w(input int mem_blocks);
    return $clog2(mem_blocks);
  endfunction

endpackage

// File: rtl/main_memory_responder_block_store.sv
// Block-wide storage with one synchronous write-first port.
// The array is never reset; only the read register is.
module block_store #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_BLOCKS = 256,
  parameter int IDX_W      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  re,
  input  logic                                  we,
  input  logic                                  rzero,
  input  logic [IDX_W-1:0]                      idx,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata
);

  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem [MEM_BLOCKS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Read register only moves on a read so it holds across writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re) begin
      if (rzero)   rdata <= '0;
      else if (we) rdata <= wdata;
      else         rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency block memory behind the L2 miss interface.
// Optional MEMRSP_BOUNDS_CHECK_EN adds mem_err for addresses beyond storage.
module main_memory_responder
  import mem_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_BLOCKS = 256,
  parameter int LATENCY    = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
  output logic                                  mem_ready,
  output logic                                  mem_hit
`ifdef MEMRSP_BOUNDS_CHECK_EN
  ,
  output logic                                  mem_err
`endif
);

  localparam int OFF_W     = off_w(BLOCK_SIZE);
  localparam int MEM_IDX_W = mem_idx_w(MEM_BLOCKS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t                                state, state_nx;
  logic [CNT_W-1:0]                      cnt;
  logic [MEM_IDX_W-1:0]                  req_idx;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wdata;
  op_t                                   req_op;
  logic                                  req_oob;
  logic                                  addr_oob;
  logic                                  fire;
  logic                                  accept;

`ifdef MEMRSP_BOUNDS_CHECK_EN
  assign addr_oob = |(mem_addr >> (OFF_W + MEM_IDX_W));
  assign mem_err  = (state == RESP) && req_oob;
`else
  assign addr_oob = 1'b0;
`endif

  assign accept = (state == IDLE) && (mem_read || mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_op    <= '0;
      req_oob   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt       <= CNT_INIT;
        req_idx   <= mem_addr[OFF_W+MEM_IDX_W-1:OFF_W];
        req_wdata <= mem_data_out;
        req_op    <= '{rd: mem_read, wr: mem_write};
        req_oob   <= addr_oob;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    fire      = 1'b0;
    mem_ready = 1'b0;
    mem_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (mem_read || mem_write) state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == '0) begin
          fire     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        mem_hit  = 1'b1;
        state_nx = RELEASE;
      end
      RELEASE: begin
        if (!mem_read && !mem_write) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Out-of-range requests never touch storage; reads of them return zero.
  block_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .MEM_BLOCKS (MEM_BLOCKS),
    .IDX_W      (MEM_IDX_W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .re    (fire && req_op.rd),
    .we    (fire && req_op.wr && !req_oob),
    .rzero (req_oob),
    .idx   (req_idx),
    .wdata (req_wdata),
    .rdata (mem_data_in)
  );

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed plus randomized bench for main_memory_responder against a block-level model.
// Build with MEMRSP_BOUNDS_CHECK_EN to exercise the mem_err variant.
module tb_main_memory_responder;
  import mem_rsp_pkg::*;

  localparam int LAT = 10;
  localparam int BW  = DEF_BLOCK_SIZE * DEF_DATA_WIDTH;

  logic        clk, rst;
  logic [31:0] mem_addr;
  block_t      mem_data_out, mem_data_in;
  logic        mem_read, mem_write, mem_ready, mem_hit;
`ifdef MEMRSP_BOUNDS_CHECK_EN
  logic        mem_err;
`endif

  main_memory_responder #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .mem_hit      (mem_hit)
`ifdef MEMRSP_BOUNDS_CHECK_EN
    ,
    .mem_err      (mem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  block_t model [256];
  block_t exp_rdata;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [31:0] a);
`ifdef MEMRSP_BOUNDS_CHECK_EN
    return (a >> 12) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: block index is address/16 mod 256; write lands before read.
  task automatic model_op(input logic [31:0] a, input block_t wd, input bit rd, input bit wr);
    int idx;
    idx = int'((a / 16) % 256);
    if (is_oob(a)) begin
      if (rd) exp_rdata = '0;
    end else begin
      if (wr) model[idx] = wd;
      if (rd) exp_rdata = model[idx];
    end
  endtask

  task automatic xact(input logic [31:0] a, input block_t wd, input bit rd, input bit wr,
                      input int hold);
    int n;
    @(negedge clk);
    chk("ready_before", mem_ready, 1);
    mem_addr = a; mem_data_out = wd; mem_read = rd; mem_write = wr;
    model_op(a, wd, rd, wr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_hit && n < 300);
    chk("latency", n, LAT + 1);
    chk("rdata", mem_data_in, exp_rdata);
`ifdef MEMRSP_BOUNDS_CHECK_EN
    chk("err", mem_err, is_oob(a));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_hit", mem_hit, 0);
      chk("hold_ready", mem_ready, 0);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (hold == 0) begin
      @(negedge clk);
      chk("release_ready", mem_ready, 0);
    end
    @(negedge clk);
    chk("idle_ready", mem_ready, 1);
    chk("idle_hit", mem_hit, 0);
  endtask

  function automatic block_t ramp(input logic [31:0] base);
    block_t b;
    for (int w = 0; w < DEF_BLOCK_SIZE; w++) b[w] = base + w;
    return b;
  endfunction

  function automatic block_t rnd_block();
    block_t b;
    for (int w = 0; w < DEF_BLOCK_SIZE; w++) b[w] = $urandom;
    return b;
  endfunction

  initial begin
    block_t      wd;
    logic [31:0] a;
    bit          rd, wr;
    for (int i = 0; i < 256; i++) model[i] = '0;
    exp_rdata = '0;
    rst = 1'b1; mem_addr = '0; mem_data_out = '0; mem_read = 1'b0; mem_write = 1'b0;

    // reset then idle
    repeat (2) @(negedge clk);
    chk("rst_ready", mem_ready, 1);
    chk("rst_hit", mem_hit, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready0", mem_ready, 1);
    chk("idle_hit0", mem_hit, 0);
    chk("idle_data0", mem_data_in, '0);

    // write ramp then read back
    xact(32'h0000_0100, ramp(32'hA000), 1'b0, 1'b1, 0);
    chk("wr_keeps_data", mem_data_in, '0);
    xact(32'h0000_0100, '0, 1'b1, 1'b0, 0);
    chk("word5", mem_data_in[5], 32'hA005);

    // simultaneous read and write
    xact(32'h0000_0040, ramp(32'h55), 1'b1, 1'b1, 0);
    chk("rw_word0", mem_data_in[0], 32'h55);

    // reset 3 cycles into BUSY of a write
    @(negedge clk);
    mem_addr = 32'h0000_0100; mem_data_out = ramp(32'hDEAD0000); mem_write = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_hit", mem_hit, 0);
    chk("midrst_ready", mem_ready, 1);
    chk("midrst_data", mem_data_in, '0);
    exp_rdata = '0;
    @(negedge clk);
    mem_write = 1'b0; rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("postrst_hit", mem_hit, 0);
    end
    xact(32'h0000_0100, '0, 1'b1, 1'b0, 0);
    chk("old_word5", mem_data_in[5], 32'hA005);

    // held request: one hit only, reserved after drop
    xact(32'h0000_0200, ramp(32'h7700), 1'b0, 1'b1, 4);
    xact(32'h0000_0200, '0, 1'b1, 1'b0, 4);

    // alias / bounds check on upper address bits
    xact(32'h0001_0100, ramp(32'hC000), 1'b0, 1'b1, 0);
    xact(32'h0000_0100, '0, 1'b1, 1'b0, 0);
    xact(32'h0001_0100, '0, 1'b1, 1'b0, 1);

    // randomized traffic over a small block window
    for (int t = 0; t < 30; t++) begin
      a = {20'h0, 4'($urandom_range(0, 7)), 4'($urandom)} << 4 >> 4;
      a = ({24'h0, 8'($urandom_range(0, 7))} << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | ({16'($urandom), 16'h0} & 32'hFFFF_F000);
      wd = rnd_block();
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      xact(a, wd, rd, wr, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
